branch_unit: RTL and testbench
==============================

BRANCH_UNIT -- requirements
Module: branch_unit

Interface
REQ-001 SHALL have parameter ADDRESS_BITS, default 16, the width of PC_in and target_PC.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 2, range 1..7, the number of squash cycles following each redirect.
REQ-003 SHALL have port clock, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, synchronous active-low reset, sampled on the rising edge of clock.
REQ-005 SHALL have port valid_in, input, 1 bit, a control-transfer instruction is presented this cycle.
REQ-006 SHALL have ports is_branch, is_jal and is_jalr, each input, 1 bit, the instruction class.
REQ-007 SHALL have port funct3, input, 3 bits, the branch condition code.
REQ-008 SHALL have port PC_in, input, ADDRESS_BITS, the PC of the presented instruction.
REQ-009 SHALL have ports rs1_data, rs2_data and imm, each input, 32 bits, the operands and the sign-extended immediate.
REQ-010 SHALL have port next_PC_select, output, 1 bit, the fetch redirect request.
REQ-011 SHALL have port target_PC, output, ADDRESS_BITS, the redirect address.
REQ-012 SHALL have port link_value, output, 32 bits, PC_in+4 for jal/jalr.
REQ-013 SHALL have port flush, output, 1 bit, squash younger instructions.
REQ-014 SHALL have port busy, output, 1 bit, high while valid_in is ignored.
REQ-015 SHALL have port misaligned, output, 1 bit, one-cycle target-misalignment fault.
REQ-016 SHALL have ports taken_count and branch_count, each output, 16 bits, statistics counters.

Function
REQ-017 SHALL implement a state machine IDLE -> REDIRECT -> FLUSH -> IDLE, with all outputs registered.
REQ-018 SHALL, in IDLE, sample valid_in at edge N and drive the result from edge N for exactly one cycle, giving a latency of 1.
REQ-019 SHALL decide branch taken by funct3: 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge; 010 and 011 never taken.
REQ-020 SHALL compute the branch and jal target as PC_in+imm, and the jalr target as (rs1_data+imm) with bit0 cleared.
REQ-021 SHALL compute the target in 32 bits, truncate it to ADDRESS_BITS, and zero-extend PC_in before adding, so addresses wrap modulo 2^ADDRESS_BITS.
REQ-022 SHALL, when several class inputs are high at once, give priority jalr > jal > branch.
REQ-023 SHALL, for a taken or jump instruction whose target[1:0] is 0, pulse next_PC_select and load target_PC for one cycle, then enter REDIRECT.
REQ-024 SHALL, for a target with target[1:0] != 0, pulse misaligned for one cycle, leave next_PC_select low, and stay in IDLE.
REQ-025 SHALL, for a not-taken branch or when no class input is high, leave next_PC_select low and stay in IDLE.
REQ-026 SHALL, in REDIRECT and FLUSH, hold flush and busy high for FLUSH_CYCLES cycles in total, counted by a 3-bit down-counter, and ignore valid_in.
REQ-027 SHALL return to IDLE after the final flush cycle, with valid_in accepted on that same edge.
REQ-028 SHALL hold target_PC at its last value when next_PC_select is low.
REQ-029 SHALL load link_value on every accepted jal/jalr and otherwise hold it.

Reset
REQ-030 SHALL, when reset=0 at an edge, go to IDLE and set next_PC_select, flush, busy and misaligned to 0; target_PC, link_value and the counters to 0.
REQ-031 SHALL, on reset during REDIRECT or FLUSH, abort the flush immediately, with no residual pulse.
REQ-032 SHALL give reset priority over valid_in on the same edge.

Configuration
REQ-033 SHALL, with BRANCH_STATS_EN defined, increment branch_count on each accepted is_branch and taken_count on each issued redirect, both saturating at 16'hFFFF.
REQ-034 SHALL, without BRANCH_STATS_EN, keep the counter ports present and tie them to 0, with no counter logic.

Verification
REQ-035 SHALL test: beq with rs1=rs2=5, PC_in=0x0010, imm=8 -> next_PC_select=1 for one cycle, target_PC=0x0018, then flush=1 for 2 cycles.
REQ-036 SHALL test: blt with rs1=-1, rs2=1 -> taken; bltu with the same operands -> not taken, next_PC_select stays 0.
REQ-037 SHALL test: jalr with rs1=0x0103, imm=0 -> target_PC=0x0102, then misaligned=1 with no redirect; jalr with rs1=0x0101 -> target_PC=0x0100, redirect issued, link_value=PC_in+4.
REQ-038 SHALL test: valid jal presented during FLUSH -> ignored, no second redirect, counts unchanged.
REQ-039 SHALL test: reset=0 in the first flush cycle -> the next cycle shows flush=0, busy=0, state IDLE.
REQ-040 SHALL test: with BRANCH_STATS_EN, 3 taken and 2 not-taken branches -> branch_count=5, taken_count=3; without the macro -> both 0.

Source files
------------

// File: rtl/branch_unit.sv
// Branch/jump resolution unit: condition evaluation, target generation and a registered
// redirect/flush sequencer. Define BRANCH_STATS_EN to build the saturating statistics counters.
module branch_unit #(
  parameter int ADDRESS_BITS = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    valid_in,
  input  logic                    is_branch,
  input  logic                    is_jal,
  input  logic                    is_jalr,
  input  logic [2:0]              funct3,
  input  logic [ADDRESS_BITS-1:0] PC_in,
  input  logic [31:0]             rs1_data,
  input  logic [31:0]             rs2_data,
  input  logic [31:0]             imm,
  output logic                    next_PC_select,
  output logic [ADDRESS_BITS-1:0] target_PC,
  output logic [31:0]             link_value,
  output logic                    flush,
  output logic                    busy,
  output logic                    misaligned,
  output logic [15:0]             taken_count,
  output logic [15:0]             branch_count
);

  typedef enum logic [1:0] {IDLE = 2'd0, REDIRECT = 2'd1, FLUSH = 2'd2} state_t;

  state_t                  state_reg, state_next;
  logic [2:0]              cnt_reg, cnt_next;
  logic                    nps_reg, nps_next;
  logic                    mis_reg, mis_next;
  logic                    flush_reg, flush_next;
  logic                    busy_reg, busy_next;
  logic [ADDRESS_BITS-1:0] target_reg, target_next;
  logic [31:0]             link_reg, link_next;

  logic [31:0] pc_ext;
  logic [31:0] target_full;
  logic        target_unused;
  logic        cond_true;
  logic        is_jump;
  logic        sel_branch;
  logic        transfer;
  logic        can_accept;
  logic        accept;
  logic        issue;
  logic        fault;

  assign pc_ext        = 32'(PC_in);
  assign target_unused = ^target_full;

  always_comb begin
    cond_true = 1'b0;
    case (funct3)
      3'b000:  cond_true = (rs1_data == rs2_data);
      3'b001:  cond_true = (rs1_data != rs2_data);
      3'b100:  cond_true = ($signed(rs1_data) <  $signed(rs2_data));
      3'b101:  cond_true = ($signed(rs1_data) >= $signed(rs2_data));
      3'b110:  cond_true = (rs1_data <  rs2_data);
      3'b111:  cond_true = (rs1_data >= rs2_data);
      default: cond_true = 1'b0;
    endcase
  end

  // jalr outranks jal, which outranks a conditional branch
  assign is_jump     = is_jalr | is_jal;
  assign sel_branch  = is_branch & ~is_jump;
  assign target_full = is_jalr ? ((rs1_data + imm) & 32'hFFFF_FFFE) : (pc_ext + imm);
  assign transfer    = is_jump | (sel_branch & cond_true);

  // The last flush cycle's closing edge already behaves as IDLE
  assign can_accept = (state_reg == IDLE) || ((state_reg == FLUSH) && (cnt_reg == 3'd0));
  assign accept     = valid_in & can_accept;
  assign issue      = accept & transfer & (target_full[1:0] == 2'b00);
  assign fault      = accept & transfer & (target_full[1:0] != 2'b00);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= 3'd0;
      nps_reg    <= 1'b0;
      mis_reg    <= 1'b0;
      flush_reg  <= 1'b0;
      busy_reg   <= 1'b0;
      target_reg <= '0;
      link_reg   <= 32'd0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      nps_reg    <= nps_next;
      mis_reg    <= mis_next;
      flush_reg  <= flush_next;
      busy_reg   <= busy_next;
      target_reg <= target_next;
      link_reg   <= link_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (issue) state_next = REDIRECT;
      end
      REDIRECT: begin
        state_next = FLUSH;
        cnt_next   = 3'(FLUSH_CYCLES - 1);
      end
      FLUSH: begin
        if (cnt_reg != 3'd0) cnt_next = cnt_reg - 3'd1;
        else                 state_next = issue ? REDIRECT : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    nps_next    = issue;
    mis_next    = fault;
    flush_next  = (state_next == FLUSH);
    busy_next   = (state_next == FLUSH);
    target_next = issue ? target_full[ADDRESS_BITS-1:0] : target_reg;
    link_next   = (accept & is_jump) ? (pc_ext + 32'd4) : link_reg;
  end

  assign next_PC_select = nps_reg;
  assign misaligned     = mis_reg;
  assign flush          = flush_reg;
  assign busy           = busy_reg;
  assign target_PC      = target_reg;
  assign link_value     = link_reg;

`ifdef BRANCH_STATS_EN
  logic [15:0] taken_count_reg;
  logic [15:0] branch_count_reg;

  always_ff @(posedge clock) begin
    if (!reset) begin
      taken_count_reg  <= 16'd0;
      branch_count_reg <= 16'd0;
    end else begin
      if (accept && sel_branch && (branch_count_reg != 16'hFFFF))
        branch_count_reg <= branch_count_reg + 16'd1;
      if (issue && (taken_count_reg != 16'hFFFF))
        taken_count_reg <= taken_count_reg + 16'd1;
    end
  end

  assign taken_count  = taken_count_reg;
  assign branch_count = branch_count_reg;
`else
  assign taken_count  = 16'd0;
  assign branch_count = 16'd0;
`endif

endmodule

// File: tb/tb_branch_unit.sv
// Scoreboard bench for branch_unit: a behavioural model predicts every cycle's outputs,
// a negedge monitor compares them against the DUT.
module tb_branch_unit;
  localparam int AB = 16;
  localparam int FC = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          valid_in;
  logic          is_branch;
  logic          is_jal;
  logic          is_jalr;
  logic [2:0]    funct3;
  logic [AB-1:0] PC_in;
  logic [31:0]   rs1_data;
  logic [31:0]   rs2_data;
  logic [31:0]   imm;
  logic          next_PC_select;
  logic [AB-1:0] target_PC;
  logic [31:0]   link_value;
  logic          flush;
  logic          busy;
  logic          misaligned;
  logic [15:0]   taken_count;
  logic [15:0]   branch_count;

  branch_unit #(.ADDRESS_BITS(AB), .FLUSH_CYCLES(FC)) dut (
    .clock(clock), .reset(reset), .valid_in(valid_in),
    .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr),
    .funct3(funct3), .PC_in(PC_in), .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .next_PC_select(next_PC_select), .target_PC(target_PC), .link_value(link_value),
    .flush(flush), .busy(busy), .misaligned(misaligned),
    .taken_count(taken_count), .branch_count(branch_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    int            edge_no;
    logic          nps;
    logic          mis;
    logic          fl;
    logic [AB-1:0] tgt;
    logic [31:0]   link;
    logic [15:0]   tc;
    logic [15:0]   bc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   edges  = 0;

  // Model state: edges still to be ignored after a redirect, plus architectural values
  int            m_block = 0;
  logic [AB-1:0] m_tgt   = '0;
  logic [31:0]   m_link  = 32'd0;
  int            m_tc    = 0;
  int            m_bc    = 0;

  always @(posedge clock) edges <= edges + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at edge %0d: got %h, expected %h", name, edges, act, expv);
    end
  endtask

  function automatic logic cond_ref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) <  $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a < b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // Drive one cycle of stimulus, predict the outcome of the coming edge, then cross it
  task automatic step(input logic rst, input logic v, input logic b, input logic j, input logic jr,
                      input logic [2:0] f3, input logic [AB-1:0] pc,
                      input logic [31:0] a, input logic [31:0] bb, input logic [31:0] im);
    exp_t        e;
    logic [31:0] t;
    logic        jump;
    logic        brn;
    reset = rst; valid_in = v; is_branch = b; is_jal = j; is_jalr = jr;
    funct3 = f3; PC_in = pc; rs1_data = a; rs2_data = bb; imm = im;
    e.edge_no = edges + 1;
    e.nps = 1'b0;
    e.mis = 1'b0;
    e.fl  = 1'b0;
    if (!rst) begin
      m_block = 0; m_tgt = '0; m_link = 32'd0; m_tc = 0; m_bc = 0;
    end else if (m_block > 0) begin
      m_block--;
      e.fl = 1'b1;
    end else if (v) begin
      jump = jr | j;
      brn  = b && !jump;
      if (jr) t = (a + im) & 32'hFFFF_FFFE;
      else    t = 32'(pc) + im;
      if (jump) m_link = 32'(pc) + 32'd4;
      if (brn && m_bc < 65535) m_bc++;
      if (jump || (brn && cond_ref(f3, a, bb))) begin
        if (t % 4 == 0) begin
          e.nps   = 1'b1;
          m_tgt   = t[AB-1:0];
          m_block = FC;
          if (m_tc < 65535) m_tc++;
        end else begin
          e.mis = 1'b1;
        end
      end
    end
    e.tgt  = m_tgt;
    e.link = m_link;
`ifdef BRANCH_STATS_EN
    e.tc = 16'(m_tc);
    e.bc = 16'(m_bc);
`else
    e.tc = 16'd0;
    e.bc = 16'd0;
`endif
    sb.push_back(e);
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, '0, 32'd0, 32'd0, 32'd0);
  endtask

  // Monitor: every cycle the DUT presents a full output set; pop the prediction for that edge
  always @(negedge clock) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].edge_no <= edges) begin
      e = sb.pop_front();
      chk("next_PC_select", 32'(next_PC_select), 32'(e.nps));
      chk("misaligned",     32'(misaligned),     32'(e.mis));
      chk("flush",          32'(flush),          32'(e.fl));
      chk("busy",           32'(busy),           32'(e.fl));
      chk("target_PC",      32'(target_PC),      32'(e.tgt));
      chk("link_value",     link_value,          e.link);
      chk("taken_count",    32'(taken_count),    32'(e.tc));
      chk("branch_count",   32'(branch_count),   32'(e.bc));
      if (e.nps || e.mis)
        $display("edge %0d: %s target_PC=%h link_value=%h", e.edge_no,
                 e.nps ? "redirect" : "misaligned", e.tgt, e.link);
    end
  end

  initial begin
    int            k;
    logic [2:0]    cls;
    logic [AB-1:0] pc;
    logic [31:0]   a;
    logic [31:0]   bb;
    logic [31:0]   im;
    logic          rst;
    int            cnt_exp_b;
    int            cnt_exp_t;
    reset = 1'b0; valid_in = 1'b0; is_branch = 1'b0; is_jal = 1'b0; is_jalr = 1'b0;
    funct3 = 3'd0; PC_in = '0; rs1_data = 32'd0; rs2_data = 32'd0; imm = 32'd0;
    @(posedge clock);
    #1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, '0, 32'd0, 32'd0, 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0100, 32'd0, 32'd0, 32'd8);

    // beq 5==5 from 0x0010 +8: redirect to 0x0018, two flush cycles
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 16'h0010, 32'd5, 32'd5, 32'd8);
    idle(3);
    // blt -1 < 1 taken; bltu 0xFFFFFFFF < 1 not taken
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b100, 16'h0020, 32'hFFFF_FFFF, 32'd1, 32'h10);
    idle(2);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b110, 16'h0020, 32'hFFFF_FFFF, 32'd1, 32'h10);
    idle(1);
    // jalr to 0x0102 faults; jalr to 0x0100 redirects with link
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 16'h0040, 32'h0000_0103, 32'd0, 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 16'h0044, 32'h0000_0101, 32'd0, 32'd0);
    idle(3);
    // jal presented while flushing is ignored
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0200, 32'd0, 32'd0, 32'h20);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0300, 32'd0, 32'd0, 32'h40);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0304, 32'd0, 32'd0, 32'h40);
    idle(1);
    // reset in the first flush cycle, then immediate acceptance
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b001, 16'h0400, 32'd1, 32'd2, 32'h8);
    idle(1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, '0, 32'd0, 32'd0, 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0500, 32'd0, 32'd0, 32'h10);
    idle(3);
    // priority: all class bits high behaves as jalr; wrap of PC_in+imm
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'b010, 16'h0600, 32'h0000_0801, 32'd7, 32'd3);
    idle(3);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 16'hFFF0, 32'd0, 32'd0, 32'h20);
    idle(3);

    // statistics: 3 taken, 2 not-taken branches from a fresh reset
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, '0, 32'd0, 32'd0, 32'd0);
    for (int n = 0; n < 5; n++) begin
      if (n % 2 == 0) begin
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 16'h0700, 32'd9, 32'd9, 32'h4);
        idle(2);
      end else begin
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b001, 16'h0700, 32'd9, 32'd9, 32'h4);
      end
    end
`ifdef BRANCH_STATS_EN
    cnt_exp_b = 5;
    cnt_exp_t = 3;
`else
    cnt_exp_b = 0;
    cnt_exp_t = 0;
`endif
    chk("stats branch_count", 32'(branch_count), 32'(cnt_exp_b));
    chk("stats taken_count",  32'(taken_count),  32'(cnt_exp_t));

    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      k = $urandom_range(0, 9);
      if (k <= 3)      cls = 3'b001;
      else if (k == 4) cls = 3'b010;
      else if (k == 5) cls = 3'b100;
      else if (k == 6) cls = 3'b000;
      else             cls = 3'($urandom_range(0, 7));
      pc = AB'($urandom_range(0, 65535));
      if ($urandom_range(0, 3) != 0) pc[1:0] = 2'b00;
      a  = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 4)) - 32'd2 : $urandom;
      bb = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 4)) - 32'd2 : $urandom;
      im = 32'($urandom_range(0, 63)) - 32'd32;
      if ($urandom_range(0, 3) != 0) im[1:0] = 2'b00;
      step(rst, ($urandom_range(0, 9) < 7), cls[0], cls[1], cls[2],
           3'($urandom_range(0, 7)), pc, a, bb, im);
    end
    idle(4);

    for (int w = 0; w < 10 && sb.size() > 0; w++) @(negedge clock);
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d predictions left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
